inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
- REQ-001 The block SHALL have parameter ADDR_W, default 8: instruction-memory address width in words.
- REQ-002 The block SHALL have parameter BASE_ADDR, default 0: first word address written.
- REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 Port rst, input, 1 bit: reset; synchronous, active-high.
- REQ-005 Port req_valid, input, 1 bit: request present.
- REQ-006 Port req_ready, output, 1 bit: block can accept a request.
- REQ-007 Port req_op, input, 4 bits: instruction class.
  - 0 R, 1 I-arith, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL.
  - 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM; 10-15 illegal.
- REQ-008 Ports req_rd, req_rs1, req_rs2, input, 5 bits each: register fields.
- REQ-009 Port req_funct3, input, 3 bits; port req_funct7b5, input, 1 bit (instruction bit 30).
- REQ-010 Port req_imm, input, 32 bits: byte-offset or upper immediate, unshifted.
- REQ-011 Port req_last, input, 1 bit: final instruction of the program.
- REQ-012 Ports mem_we, output, 1 bit; mem_addr, output, ADDR_W bits; mem_wdata, output, 32 bits: instruction-memory write port.
- REQ-013 Port done, output, 1 bit: program load complete.
- REQ-014 Port count, output, ADDR_W+1 bits: words written.
- REQ-015 Port err, output, 1 bit: sticky illegal-request flag.

Function
- REQ-016 The FSM SHALL have states IDLE, ENC, WR and DONE.
  - IDLE→ENC on req_valid&&req_ready.
  - ENC→WR unconditionally.
  - WR→DONE if the latched last bit is set or mem_addr equals all-ones; WR→IDLE otherwise.
  - DONE holds until rst.
- REQ-017 req_ready SHALL be 1 only in IDLE with rst low.
- REQ-018 On acceptance, all request fields SHALL be latched; inputs are don't-care afterward.
- REQ-019 In ENC the registered 32-bit word SHALL be formed per RV32I.
  - Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
- REQ-020 Field rules:
  - R: funct7 = {0, funct7b5, 00000}.
  - I-arith with funct3 001/101: bits[31:25] = {0, funct7b5, 00000}, bits[24:20] = imm[4:0].
  - Other I-type/LOAD/JALR/SYSTEM: imm[11:0].
  - STORE: imm[11:5] | imm[4:0] split.
  - BRANCH: imm[12|10:5|4:1|11].
  - JAL: imm[20|10:1|11|19:12].
  - LUI/AUIPC: imm[31:12].
  - Unused register fields are encoded as 0.
- REQ-021 mem_we SHALL be 1 for exactly one cycle in WR, with mem_wdata and mem_addr stable; a request accepted at edge N writes at edge N+2.
- REQ-022 mem_addr SHALL increment by 1 after each write and count SHALL increment by 1; mem_addr never wraps.
- REQ-023 Write after write to all-ones address SHALL enter DONE.
- REQ-024 done SHALL be 1 exactly in DONE; requests are not accepted in DONE.
- REQ-025 The maximum accept rate SHALL be one request per 3 cycles.

Reset
- REQ-026 While rst=1 at a clock edge, the block SHALL set:
  - state IDLE, mem_addr BASE_ADDR, count 0.
  - mem_we 0, mem_wdata 0, done 0, err 0.
  - req_ready 0.
- REQ-027 rst in ENC or WR SHALL abort the operation: no write occurs at or after that edge, and the latched request is discarded.

Configuration
- REQ-028 Macro INST_ENCODER_CHECK_EN defined SHALL enable checking; an illegal req_op, a BRANCH with imm[0]=1 or outside signed 13-bit range, or a JAL with imm[0]=1 or outside signed 21-bit range SHALL:
  - set err=1 (sticky),
  - suppress the write, and leave mem_addr and count unchanged,
  - return WR→IDLE, or →DONE if last.
- REQ-029 Without the macro, err SHALL be tied 0, illegal req_op SHALL write NOP 0x00000013, and out-of-range immediates SHALL be truncated silently.

Verification
- REQ-030 Request op=1, rd=1, rs1=0, f3=0, imm=5 accepted at edge N → mem_we=1 at N+2, addr 0, wdata 0x00500093, count 1.
- REQ-031 Sequence:
  - op=0, rd=3, rs1=1, rs2=2, f7b5=0 → 0x002081B3 at addr 0.
  - Same with f7b5=1 → 0x402081B3 at addr 1.
- REQ-032 Encoding checks:
  - op=3, rs1=1, rs2=2, f3=2, imm=8 → 0x0020A423.
  - op=5, rd=1, imm=8 → 0x008000EF.
- REQ-033 ADDR_W=2, five back-to-back requests, none last → four writes at addr 0-3, then done=1, count=4, req_ready stays 0, fifth request never accepted.
- REQ-034 rst pulsed while in ENC → no mem_we; next cycle req_ready=1, mem_addr=0, count=0.
- REQ-035 req_op=15 → with INST_ENCODER_CHECK_EN: err=1, no write, count unchanged; without: 0x00000013 written, err=0.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: loads a program into instruction memory. Each accepted request
// is encoded into one 32-bit RV32I word and written to the next word address.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE, rst low)
//   req_op                   instruction class (0..9 legal, 10..15 illegal)
//   req_rd/rs1/rs2           register fields
//   req_funct3, req_funct7b5 funct3 and instruction bit 30
//   req_imm                  unshifted byte offset or upper immediate
//   req_last                 final instruction of the program
//   mem_we/mem_addr/mem_wdata instruction-memory write port
//   done                     program load complete (held until rst)
//   count                    words written
//   err                      sticky illegal-request flag
//
// Build option: define INST_ENCODER_CHECK_EN to reject illegal ops and
// misaligned/out-of-range BRANCH/JAL offsets (sets err, skips the write).
// Without it, illegal ops write NOP and offsets are truncated.
module inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [31:0]       req_imm,
  input  logic              req_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);
  localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   C_ONE = 1;

  typedef enum logic [1:0] {IDLE, ENC, WR, DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_op;
  logic [4:0]        r_rd, r_rs1, r_rs2;
  logic [2:0]        r_f3;
  logic              r_f7b5;
  logic [31:0]       r_imm;
  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       w_word;
  logic [6:0]        w_f7;
  logic              w_bad;

  assign w_f7 = {1'b0, r_f7b5, 5'b00000};

  // RV32I field packing from the latched request
  always_comb begin
    w_word = 32'h0000_0013;
    case (r_op)
      4'd0: w_word = {w_f7, r_rs2, r_rs1, r_f3, r_rd, 7'b0110011};
      4'd1: begin
        // shifts carry funct7 in the upper bits and shamt in imm[4:0]
        if (r_f3 == 3'b001 || r_f3 == 3'b101)
          w_word = {w_f7, r_imm[4:0], r_rs1, r_f3, r_rd, 7'b0010011};
        else
          w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, 7'b0010011};
      end
      4'd2: w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, 7'b0000011};
      4'd3: w_word = {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], 7'b0100011};
      4'd4: w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3,
                      r_imm[4:1], r_imm[11], 7'b1100011};
      4'd5: w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12],
                      r_rd, 7'b1101111};
      4'd6: w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, 7'b1100111};
      4'd7: w_word = {r_imm[31:12], r_rd, 7'b0110111};
      4'd8: w_word = {r_imm[31:12], r_rd, 7'b0010111};
      4'd9: w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, 7'b1110011};
      default: w_word = 32'h0000_0013;
    endcase
  end

`ifdef INST_ENCODER_CHECK_EN
  logic r_err;
  // offsets must be even and sign-representable in the target field
  assign w_bad = (r_op > 4'd9) ||
                 (r_op == 4'd4 && (r_imm[0] || r_imm[31:12] != {20{r_imm[12]}})) ||
                 (r_op == 4'd5 && (r_imm[0] || r_imm[31:20] != {12{r_imm[20]}}));
  assign err   = r_err;
`else
  assign w_bad = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= BASE;
      r_count <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_f3    <= '0;
      r_f7b5  <= 1'b0;
      r_imm   <= '0;
      r_last  <= 1'b0;
`ifdef INST_ENCODER_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_op    <= req_op;
          r_rd    <= req_rd;
          r_rs1   <= req_rs1;
          r_rs2   <= req_rs2;
          r_f3    <= req_funct3;
          r_f7b5  <= req_funct7b5;
          r_imm   <= req_imm;
          r_last  <= req_last;
          r_state <= ENC;
        end
        ENC: begin
          r_wdata <= w_word;
          r_we    <= !w_bad;
`ifdef INST_ENCODER_CHECK_EN
          if (w_bad) r_err <= 1'b1;
`endif
          r_state <= WR;
        end
        WR: begin
          r_we <= 1'b0;
          if (r_we) begin
            r_count <= r_count + C_ONE;
            // address saturates at all-ones; that write ends the program
            if (&r_addr) r_state <= DONE;
            else begin
              r_addr  <= r_addr + A_ONE;
              r_state <= r_last ? DONE : IDLE;
            end
          end else begin
            r_state <= r_last ? DONE : IDLE;
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) && !rst;
  // gated by rst so an abort in WR never produces a write at that edge
  assign mem_we    = r_we && !rst;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign done      = (r_state == DONE);
  assign count     = r_count;
endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  localparam int AW = 2;
  localparam int NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = '0;
  logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [2:0]    req_funct3 = '0;
  logic          req_funct7b5 = 1'b0;
  logic [31:0]   req_imm = '0;
  logic          req_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          done;
  logic [AW:0]   count;
  logic          err;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct7b5(req_funct7b5), .req_imm(req_imm),
    .req_last(req_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  // program-level model: words written so far, done, sticky err
  int m_count = 0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference encoding built from the RV32I field placement rules
  function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
      input int rs2, input int f3, input int f7b5, input logic [31:0] imm);
    logic [31:0] regs;
    logic [31:0] i12;
    i12  = (imm & 32'hfff) << 20;
    regs = (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
    case (op)
      0: return 32'h33 | regs | (32'(rs2) << 20) | (32'(f7b5) << 30);
      1: if (f3 == 1 || f3 == 5)
           return 32'h13 | regs | ((imm & 31) << 20) | (32'(f7b5) << 30);
         else return 32'h13 | regs | i12;
      2: return 32'h03 | regs | i12;
      3: return 32'h23 | ((imm & 31) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                | (32'(rs2) << 20) | (((imm >> 5) & 127) << 25);
      4: return 32'h63 | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8)
                | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
      5: return 32'h6f | (32'(rd) << 7) | (((imm >> 12) & 255) << 12)
                | (((imm >> 11) & 1) << 20) | (((imm >> 1) & 1023) << 21)
                | (((imm >> 20) & 1) << 31);
      6: return 32'h67 | regs | i12;
      7: return 32'h37 | (32'(rd) << 7) | (imm & 32'hfffff000);
      8: return 32'h17 | (32'(rd) << 7) | (imm & 32'hfffff000);
      9: return 32'h73 | regs | i12;
      default: return 32'h13;
    endcase
  endfunction

  function automatic bit is_bad(input int op, input logic [31:0] imm);
`ifdef INST_ENCODER_CHECK_EN
    int s;
    s = $signed(imm);
    if (op > 9) return 1'b1;
    if (op == 4 && (imm[0] || s < -4096 || s > 4095)) return 1'b1;
    if (op == 5 && (imm[0] || s < -1048576 || s > 1048575)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (mem_we) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%h data=%h (t=%0t)", mem_addr, mem_wdata, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("wr_addr", 32'(mem_addr), e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic chk_status();
    int ea;
    ea = (m_count > NWORDS - 1) ? NWORDS - 1 : m_count;
    chk("ready", 32'(req_ready), 32'(!m_done));
    chk("done", 32'(done), 32'(m_done));
    chk("count", 32'(count), 32'(m_count));
    chk("err", 32'(err), 32'(m_err));
    chk("addr", 32'(mem_addr), 32'(ea));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_count = 0; m_done = 1'b0; m_err = 1'b0;
  endtask

  // abort: 0 none, 1 reset during ENC, 2 reset during WR
  task automatic send(input int op, input int rd, input int rs1, input int rs2,
      input int f3, input int f7b5, input logic [31:0] imm, input bit last,
      input bit use_ovr, input logic [31:0] ovr, input int abort);
    bit bad;
    exp_t e;
    req_op = 4'(op); req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2);
    req_funct3 = 3'(f3); req_funct7b5 = f7b5[0]; req_imm = imm; req_last = last;
    req_valid = 1'b1;
    @(negedge clk);
    chk_status();
    if (req_ready && !m_done) begin
      bad = is_bad(op, imm);
      if (!bad && abort == 0) begin
        e.addr = 32'(m_count);
        e.data = use_ovr ? ovr : ref_enc(op, rd, rs1, rs2, f3, f7b5, imm);
        e.cyc  = cyc + 2;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op = 4'($urandom); req_imm = $urandom; req_rd = 5'($urandom);
      req_last = 1'($urandom);
      if (abort == 1) begin
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        m_count = 0; m_done = 1'b0; m_err = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (abort == 2) begin
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        m_count = 0; m_done = 1'b0; m_err = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (bad) begin
        m_err = 1'b1;
        if (last) m_done = 1'b1;
      end else begin
        m_count++;
        if (last || m_count == NWORDS) m_done = 1'b1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("no_accept", 32'(req_ready), 0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic settle_check();
    @(negedge clk);
    chk_status();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] imm;
    int op, n;
    do_reset();

    // I-arith addi x1, x0, 5
    send(1, 1, 0, 0, 0, 0, 32'd5, 1'b0, 1'b1, 32'h0050_0093, 0);
    settle_check();

    // R add / sub, then store and jal filling the 4-word memory
    do_reset();
    send(0, 3, 1, 2, 0, 0, 32'd0, 1'b0, 1'b1, 32'h0020_81B3, 0);
    send(0, 3, 1, 2, 0, 1, 32'd0, 1'b0, 1'b1, 32'h4020_81B3, 0);
    send(3, 0, 1, 2, 2, 0, 32'd8, 1'b0, 1'b1, 32'h0020_A423, 0);
    send(5, 1, 0, 0, 0, 0, 32'd8, 1'b0, 1'b1, 32'h0080_00EF, 0);
    settle_check();

    // five back-to-back, none last: fifth is refused once memory is full
    do_reset();
    for (int i = 0; i < 5; i++)
      send(1, i + 1, i, 0, 0, 0, 32'(i), 1'b0, 1'b0, 32'h0, 0);
    settle_check();

    // reset while in ENC, then while in WR
    do_reset();
    send(7, 5, 0, 0, 0, 0, 32'h1234_5000, 1'b0, 1'b0, 32'h0, 1);
    settle_check();
    send(7, 5, 0, 0, 0, 0, 32'h1234_5000, 1'b0, 1'b0, 32'h0, 2);
    settle_check();

    // illegal op, then a legal word to show addr/count unaffected
    do_reset();
    send(15, 1, 2, 3, 0, 0, 32'd0, 1'b0, 1'b0, 32'h0, 0);
    settle_check();
    send(9, 0, 0, 0, 0, 0, 32'd1, 1'b0, 1'b0, 32'h0, 0);
    settle_check();

    // randomized programs
    for (int p = 0; p < 40; p++) begin
      do_reset();
      n = 0;
      while (!m_done && n < 8) begin
        op  = ($urandom % 8 == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        imm = $urandom;
        case ($urandom % 3)
          0: imm = 32'($signed(imm[12:0])) & 32'hffff_fffe;
          1: imm = 32'($signed(imm[20:0])) & 32'hffff_fffe;
          default: ;
        endcase
        send(op, $urandom % 32, $urandom % 32, $urandom % 32, $urandom % 8,
             $urandom % 2, imm, ($urandom % 6 == 0), 1'b0, 32'h0, 0);
        n++;
      end
      if (m_done)
        send(1, 1, 1, 1, 0, 0, 32'd1, 1'b0, 1'b0, 32'h0, 0);
      settle_check();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
